// File: rtl/ov7670_capture.sv
// ov7670_capture
//   Camera-side pixel assembler for an OV7670 RGB565 stream. It packs byte
//   pairs into 16-bit pixels and writes them to a frame buffer at the linear
//   address y*H_ACT + x. Over-long lines and frames are clipped. The block
//   reports per-line byte-count errors and per-frame integrity.
//
// Parameters
//   H_ACT   active pixels per line (also the write-address stride)
//   V_ACT   active lines per frame
//   ADDR_W  width of waddr_o; 2**ADDR_W must be >= H_ACT*V_ACT
//
// Ports
//   clk_i         camera pixel clock (the only clock)
//   rst_ni        asynchronous active-low reset
//   vsync_i       frame sync, high during vertical blanking
//   href_i        line valid, high while pixel bytes are on data_i
//   data_i        camera byte bus
//   we_o          frame buffer write enable, one-cycle pulse per pixel
//   waddr_o       frame buffer write address
//   wdata_o       RGB565 pixel {first byte, second byte}
//   frame_done_o  one-cycle pulse at the end of every captured frame
//   frame_ok_o    qualifies frame_done_o: exactly V_ACT lines, no line error
//   line_err_o    one-cycle pulse when a line ends with a bad byte count
module ov7670_capture #(
    parameter int H_ACT  = 320,
    parameter int V_ACT  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vsync_i,
    input  logic              href_i,
    input  logic [7:0]        data_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [15:0]       wdata_o,
    output logic              frame_done_o,
    output logic              frame_ok_o,
    output logic              line_err_o
);

    localparam int CW = 10;
    localparam logic [CW-1:0]     H_C    = CW'(H_ACT);
    localparam logic [CW-1:0]     V_C    = CW'(V_ACT);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_ACT);

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

    state_t            state_q;
    logic              vsync_q;
    logic              href_q;
    logic              phase_q;
    logic [7:0]        hi_q;
    logic [CW-1:0]     x_q;
    logic [CW-1:0]     y_q;
    logic [ADDR_W-1:0] line_base_q;
    logic              frame_err_q;

    logic              vs_rise;
    logic              vs_fall;
    logic              line_end;
    logic              line_bad;
    logic              wr_ok;
    logic [CW-1:0]     x_inc_d;
    logic [CW-1:0]     y_inc_d;
    logic [CW-1:0]     y_d;
    logic              frame_err_d;
    logic              frame_ok_d;

    always_comb begin
        vs_rise  = vsync_i && !vsync_q;
        vs_fall  = !vsync_i && vsync_q;
        line_end = href_q && !href_i;
        // A line is good only with exactly H_ACT pixels and no dangling byte.
        line_bad = (x_q != H_C) || phase_q;
        wr_ok    = (x_q < H_C) && (y_q < V_C);
        x_inc_d  = (x_q == '1) ? x_q : x_q + 1'b1;
        y_inc_d  = (y_q == '1) ? y_q : y_q + 1'b1;
        // Line-end bookkeeping of this cycle is folded in so that a vsync
        // rise coinciding with a line end reports the completed line.
        y_d         = line_end ? y_inc_d : y_q;
        frame_err_d = frame_err_q || (line_end && line_bad);
        frame_ok_d  = (y_d == V_C) && !frame_err_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            line_base_q  <= '0;
            frame_err_q  <= 1'b0;
            we_o         <= 1'b0;
            waddr_o      <= '0;
            wdata_o      <= '0;
            frame_done_o <= 1'b0;
            frame_ok_o   <= 1'b0;
            line_err_o   <= 1'b0;
        end else begin
            vsync_q      <= vsync_i;
            href_q       <= href_i;
            we_o         <= 1'b0;
            frame_done_o <= 1'b0;
            frame_ok_o   <= 1'b0;
            line_err_o   <= 1'b0;

            case (state_q)
                // Wait for blanking so a partial frame after reset is skipped.
                IDLE: begin
                    if (vsync_i) state_q <= SYNC;
                end

                SYNC: begin
                    if (vs_fall) begin
                        state_q     <= ACTIVE;
                        x_q         <= '0;
                        y_q         <= '0;
                        line_base_q <= '0;
                        phase_q     <= 1'b0;
                        frame_err_q <= 1'b0;
                    end
                end

                ACTIVE: begin
                    if (href_i) begin
                        phase_q <= ~phase_q;
                        if (!phase_q) begin
                            hi_q <= data_i;
                        end else begin
                            if (wr_ok) begin
                                we_o    <= 1'b1;
                                waddr_o <= line_base_q + ADDR_W'(x_q);
                                wdata_o <= {hi_q, data_i};
                            end
                            x_q <= x_inc_d;
                        end
                    end else if (line_end) begin
                        // Any dangling half pixel is simply dropped here.
                        line_err_o  <= line_bad;
                        frame_err_q <= frame_err_d;
                        y_q         <= y_inc_d;
                        // Base stops advancing once writes are clipped, so it
                        // can never wrap on very long frames.
                        if (y_q < V_C) line_base_q <= line_base_q + STRIDE;
                        x_q         <= '0;
                        phase_q     <= 1'b0;
                    end

                    if (vs_rise) begin
                        state_q      <= SYNC;
                        frame_done_o <= 1'b1;
                        frame_ok_o   <= frame_ok_d;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
module tb_ov7670_capture;

    localparam int H  = 320;
    localparam int V  = 6;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          we_o;
    logic [AW-1:0] waddr_o;
    logic [15:0]   wdata_o;
    logic          frame_done_o;
    logic          frame_ok_o;
    logic          line_err_o;

    ov7670_capture #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .vsync_i     (vsync),
        .href_i      (href),
        .data_i      (data),
        .we_o        (we_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .frame_done_o(frame_done_o),
        .frame_ok_o  (frame_ok_o),
        .line_err_o  (line_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   pix;
        int            stamp;
    } wr_t;

    typedef struct {
        logic ok;
        int   stamp;
    } fr_t;

    wr_t wq[$];
    int  lq[$];
    fr_t fq[$];

    int  n_chk = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    int  lb[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic prev_we;
        wr_t  w;
        fr_t  f;
        int   s;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (we_o) begin
                    chk("we_adjacent", 32'(prev_we), 32'd0);
                    if (wq.size() == 0) begin
                        chk("we_unexpected", 32'(we_o), 32'd0);
                    end else begin
                        w = wq.pop_front();
                        chk("waddr", 32'(waddr_o), 32'(w.addr));
                        chk("wdata", 32'(wdata_o), 32'(w.pix));
                        chk("we_latency", 32'(cyc), 32'(w.stamp));
                    end
                end
                if (line_err_o) begin
                    if (lq.size() == 0) begin
                        chk("line_err_unexpected", 32'(line_err_o), 32'd0);
                    end else begin
                        s = lq.pop_front();
                        chk("line_err_time", 32'(cyc), 32'(s));
                    end
                end
                if (frame_done_o) begin
                    if (fq.size() == 0) begin
                        chk("frame_done_unexpected", 32'(frame_done_o), 32'd0);
                    end else begin
                        f = fq.pop_front();
                        chk("frame_ok", 32'(frame_ok_o), 32'(f.ok));
                        chk("frame_done_time", 32'(cyc), 32'(f.stamp));
                    end
                end else if (frame_ok_o) begin
                    chk("frame_ok_without_done", 32'(frame_ok_o), 32'd0);
                end
            end
            prev_we = we_o;
        end
    endtask

    function automatic logic [7:0] bval(input int f, input int y, input int i);
        if (f == 0 && y == 1 && i == 10) return 8'hF8;
        if (f == 0 && y == 1 && i == 11) return 8'h1F;
        return 8'(f * 5 + y * 37 + i * 11 + 3);
    endfunction

    task automatic set_lines(input int nb);
        for (int k = 0; k < 32; k++) lb[k] = nb;
    endtask

    // Drives one frame; lb[] holds the byte count of every line.
    task automatic run_frame(input int f, input int nlines, input bit vs_at_end);
        logic [7:0] b;
        logic [7:0] hi;
        bit         err;
        err = 1'b0;
        hi  = 8'h00;
        @(posedge clk); #1;
        href  = 1'b0;
        vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b0;
        repeat (2) @(posedge clk);
        for (int y = 0; y < nlines; y++) begin
            for (int i = 0; i < lb[y]; i++) begin
                @(posedge clk); #1;
                b    = bval(f, y, i);
                href = 1'b1;
                data = b;
                if (i % 2 == 0) begin
                    hi = b;
                end else if ((i / 2) < H && y < V) begin
                    wq.push_back('{addr: AW'(y * H + i / 2), pix: {hi, b}, stamp: cyc + 1});
                end
            end
            @(posedge clk); #1;
            href = 1'b0;
            data = 8'h00;
            if (lb[y] != 2 * H) begin
                err = 1'b1;
                lq.push_back(cyc + 1);
            end
            if (vs_at_end && y == nlines - 1) begin
                vsync = 1'b1;
                fq.push_back('{ok: (nlines == V) && !err, stamp: cyc + 1});
            end else begin
                repeat (3) @(posedge clk);
            end
        end
        if (!vs_at_end) begin
            @(posedge clk); #1;
            vsync = 1'b1;
            fq.push_back('{ok: (nlines == V) && !err, stamp: cyc + 1});
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none

        // Reset mid-line: capture one pixel, then assert reset while it is on the port.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1 vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1 href = 1'b1; data = 8'hAB;
        @(posedge clk); #1 data = 8'hCD;
        @(posedge clk); #2;
        chk("pre_reset_we", 32'(we_o), 32'd1);
        chk("pre_reset_waddr", 32'(waddr_o), 32'd0);
        chk("pre_reset_wdata", 32'(wdata_o), 32'hABCD);
        rst_n = 1'b0;
        #1;
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_waddr", 32'(waddr_o), 32'd0);
        chk("rst_wdata", 32'(wdata_o), 32'd0);
        chk("rst_frame_done", 32'(frame_done_o), 32'd0);
        chk("rst_frame_ok", 32'(frame_ok_o), 32'd0);
        chk("rst_line_err", 32'(line_err_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Active-looking traffic after release must produce no writes or pulses.
        for (int i = 0; i < 700; i++) begin
            @(posedge clk); #1;
            href = ((i % 400) < 380);
            data = 8'(i);
        end
        #1 vsync = 1'b1;
        repeat (5) @(posedge clk);

        set_lines(2 * H); run_frame(0, V, 1'b0);        // nominal, F81F at 325
        set_lines(2 * H); lb[2] = 644; run_frame(1, V, 1'b0);  // 322-pixel line
        set_lines(2 * H); lb[3] = 641; run_frame(2, V, 1'b0);  // odd byte count
        set_lines(2 * H); run_frame(3, 16, 1'b0);       // too many lines
        set_lines(2 * H); run_frame(4, V - 1, 1'b0);    // one line short
        set_lines(2 * H); run_frame(5, V, 1'b1);        // vsync with last line end
        set_lines(2 * H); lb[V - 1] = 638; run_frame(6, V, 1'b1);
        set_lines(2 * H); run_frame(7, V, 1'b0);        // clean frame after errors

        repeat (10) @(posedge clk);
        #1;
        chk("writes_outstanding", 32'(wq.size()), 32'd0);
        chk("line_err_outstanding", 32'(lq.size()), 32'd0);
        chk("frame_done_outstanding", 32'(fq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
